// File: rtl/cordic_pkg.sv
// Constants shared by the vectoring and rotation CORDIC pipelines (Q.10 fixed point).
package cordic_pkg;

  localparam int FXP_MUL     = 1024;
  localparam int KN_FXP      = 622;
  localparam int HALF_PI_FXP = 1608;
  localparam int PI_FXP      = 3217;
  localparam int N_STAGES    = 11;

  // Truncated atan(2^-i) * 1024 for micro-rotation i.
  function automatic int atan_fxp(input int i);
    case (i)
      0:       return 804;
      1:       return 474;
      2:       return 250;
      3:       return 127;
      4:       return 63;
      5:       return 31;
      6:       return 15;
      7:       return 7;
      8:       return 3;
      9:       return 1;
      default: return 0;
    endcase
  endfunction

endpackage

// File: rtl/cordic_vector_pipeline_if.sv
// Sample/result bundle of the vectoring CORDIC: clock enable, input vector, angle and magnitude.
interface cordic_vector_pipeline_if #(
  parameter int W = 12
);

  logic                ce;
  logic                valid_in;
  logic signed [W-1:0] x_in;
  logic signed [W-1:0] y_in;
  logic signed [W:0]   angle_out;
  logic signed [W-1:0] mag_out;
  logic                valid_out;

  modport master (
    output ce, valid_in, x_in, y_in,
    input  angle_out, mag_out, valid_out
  );

  modport slave (
    input  ce, valid_in, x_in, y_in,
    output angle_out, mag_out, valid_out
  );

endinterface

// File: rtl/cordic_vec_step.sv
// One registered vectoring micro-rotation: steers y toward zero by +/-atan(2^-SHIFT).
module cordic_vec_step #(
  parameter int SHIFT = 0,
  parameter int IW    = 14,
  parameter int ZW    = 13,
  parameter int ATAN  = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 i_ce,
  input  logic                 i_valid,
  input  logic signed [IW-1:0] i_x,
  input  logic signed [IW-1:0] i_y,
  input  logic signed [ZW-1:0] i_z,
  output logic                 o_valid,
  output logic signed [IW-1:0] o_x,
  output logic signed [IW-1:0] o_y,
  output logic signed [ZW-1:0] o_z
);

  logic signed [IW-1:0] w_x_sh;
  logic signed [IW-1:0] w_y_sh;
  logic signed [ZW-1:0] w_atan;
  logic                 r_valid;
  logic signed [IW-1:0] r_x;
  logic signed [IW-1:0] r_y;
  logic signed [ZW-1:0] r_z;

  assign w_x_sh = i_x >>> SHIFT;
  assign w_y_sh = i_y >>> SHIFT;
  assign w_atan = ZW'(ATAN);

  // Rotate against the sign of y, all updates from the pre-stage values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_valid <= 1'b0;
      r_x     <= '0;
      r_y     <= '0;
      r_z     <= '0;
    end else if (i_ce) begin
      r_valid <= i_valid;
      if (!i_y[IW-1]) begin
        r_x <= i_x + w_y_sh;
        r_y <= i_y - w_x_sh;
        r_z <= i_z + w_atan;
      end else begin
        r_x <= i_x - w_y_sh;
        r_y <= i_y + w_x_sh;
        r_z <= i_z - w_atan;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_x     = r_x;
  assign o_y     = r_y;
  assign o_z     = r_z;

endmodule

// File: rtl/cordic_vector_pipeline.sv
// Vectoring-mode CORDIC: (x, y) -> (atan2(y, x), |v|), 13 register stages, one sample per ce cycle.
module cordic_vector_pipeline #(
  parameter int W       = 12,
  parameter int FXP_MUL = 1024,
  parameter int IW      = 14
) (
  input logic                     clock,
  input logic                     reset,
  cordic_vector_pipeline_if.slave bus
);

  import cordic_pkg::KN_FXP;
  import cordic_pkg::HALF_PI_FXP;
  import cordic_pkg::N_STAGES;
  import cordic_pkg::atan_fxp;

  localparam int ZW   = W + 1;
  localparam int NS   = N_STAGES;
  localparam int KW   = 12;
  localparam int PW   = IW + KW;
  localparam int FRAC = $clog2(FXP_MUL);
  localparam logic signed [PW-1:0] KN_WIDE = PW'(KN_FXP);
  localparam logic signed [PW-1:0] MAG_MAX = PW'((1 << (W - 1)) - 1);

  logic signed [IW-1:0] w_x_in;
  logic signed [IW-1:0] w_y_in;
  logic                 r_p_valid;
  logic signed [IW-1:0] r_p_x;
  logic signed [IW-1:0] r_p_y;
  logic signed [ZW-1:0] r_p_z;

  logic                 w_valid [0:NS];
  logic signed [IW-1:0] w_x     [0:NS];
  logic signed [IW-1:0] w_y     [0:NS];
  logic signed [ZW-1:0] w_z     [0:NS];

  logic signed [PW-1:0] w_x_wide;
  logic signed [PW-1:0] w_prod;
  logic signed [PW-1:0] w_scaled;
  logic signed [W-1:0]  w_mag;
  logic                 w_unused_y;
  logic                 r_k_valid;
  logic signed [ZW-1:0] r_k_angle;
  logic signed [W-1:0]  r_k_mag;

  assign w_x_in = {{(IW - W){bus.x_in[W-1]}}, bus.x_in};
  assign w_y_in = {{(IW - W){bus.y_in[W-1]}}, bus.y_in};

  // Pre-rotation folds the left half-plane into the right by +/-90 degrees.
  // NOTE: sequential state uses <= so every register samples pre-edge values.
  // NOTE: data registers are reset too, so a reset also forces the result outputs to 0.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_p_valid <= 1'b0;
      r_p_x     <= '0;
      r_p_y     <= '0;
      r_p_z     <= '0;
    end else if (bus.ce) begin
      r_p_valid <= bus.valid_in;
      if (!w_x_in[IW-1]) begin
        r_p_x <= w_x_in;
        r_p_y <= w_y_in;
        r_p_z <= '0;
      end else if (!w_y_in[IW-1]) begin
        r_p_x <= w_y_in;
        r_p_y <= -w_x_in;
        r_p_z <= ZW'(HALF_PI_FXP);
      end else begin
        r_p_x <= -w_y_in;
        r_p_y <= w_x_in;
        r_p_z <= -ZW'(HALF_PI_FXP);
      end
    end
  end

  assign w_valid[0] = r_p_valid;
  assign w_x[0]     = r_p_x;
  assign w_y[0]     = r_p_y;
  assign w_z[0]     = r_p_z;

  for (genvar gi = 0; gi < NS; gi++) begin : g_stage
    cordic_vec_step #(
      .SHIFT (gi),
      .IW    (IW),
      .ZW    (ZW),
      .ATAN  (atan_fxp(gi))
    ) u_step (
      .clock   (clock),
      .reset   (reset),
      .i_ce    (bus.ce),
      .i_valid (w_valid[gi]),
      .i_x     (w_x[gi]),
      .i_y     (w_y[gi]),
      .i_z     (w_z[gi]),
      .o_valid (w_valid[gi+1]),
      .o_x     (w_x[gi+1]),
      .o_y     (w_y[gi+1]),
      .o_z     (w_z[gi+1])
    );
  end

  // The final residual y is only a convergence by-product.
  assign w_unused_y = ^w_y[NS];

  // Remove the CORDIC gain: x * Kn, back to Q.10 by arithmetic shift.
  assign w_x_wide = {{KW{w_x[NS][IW-1]}}, w_x[NS]};
  assign w_prod   = w_x_wide * KN_WIDE;
  assign w_scaled = w_prod >>> FRAC;

  // Saturate the magnitude to the largest positive output code.
  // NOTE: give every always_comb output a default first so no path infers a latch.
  always_comb begin
    w_mag = w_scaled[W-1:0];
    if (w_scaled > MAG_MAX) w_mag = W'(MAG_MAX);
  end

  // Output stage registers the scaled magnitude and the accumulated angle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_k_valid <= 1'b0;
      r_k_angle <= '0;
      r_k_mag   <= '0;
    end else if (bus.ce) begin
      r_k_valid <= w_valid[NS];
      r_k_angle <= w_z[NS];
      r_k_mag   <= w_mag;
    end
  end

  assign bus.valid_out = r_k_valid;
  assign bus.angle_out = r_k_angle;
  assign bus.mag_out   = r_k_mag;

endmodule

// File: tb/tb_cordic_vector_pipeline.sv
// Scoreboard bench: bit-true algorithm model plus real-valued atan2/hypot accuracy bounds.
module tb_cordic_vector_pipeline;

  localparam int    W       = 12;
  localparam int    ANG_TOL = 16;
  localparam int    MAG_TOL = 8;
  localparam real   PI_R    = 3.14159265358979;
  localparam int    LAT     = 13;

  typedef struct {
    int  x;
    int  y;
    int  exp_ang;
    int  exp_mag;
    int  exp_edge;
    real ideal_ang;
    real ideal_mag;
    bit  chk_ang;
  } sb_t;

  logic clock;
  logic reset;
  int   n_checks;
  int   n_errors;
  int   ce_count;
  int   out_count;
  sb_t  sb [$];
  int   rnd_x [64];
  int   rnd_y [64];
  int   atan_tab [11] = '{804, 474, 250, 127, 63, 31, 15, 7, 3, 1, 0};

  cordic_vector_pipeline_if #(.W(W)) bus ();

  cordic_vector_pipeline #(.W(W), .FXP_MUL(1024), .IW(14)) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  // Integer model of the vectoring algorithm (pre-rotation, 11 micro-rotations, gain removal).
  function automatic void model(input int x, input int y, output int ang, output int mag);
    int xs, ys, zs, xn, yn;
    if (x >= 0) begin
      xs = x;  ys = y;  zs = 0;
    end else if (y >= 0) begin
      xs = y;  ys = -x; zs = 1608;
    end else begin
      xs = -y; ys = x;  zs = -1608;
    end
    for (int i = 0; i < 11; i++) begin
      if (ys >= 0) begin
        xn = xs + (ys >>> i); yn = ys - (xs >>> i); zs = zs + atan_tab[i];
      end else begin
        xn = xs - (ys >>> i); yn = ys + (xs >>> i); zs = zs - atan_tab[i];
      end
      xs = xn;
      ys = yn;
    end
    ang = zs;
    mag = (xs * 622) >>> 10;
    if (mag > 2047) mag = 2047;
  endfunction

  task automatic push(input int x, input int y, input real ia, input real im, input bit ca);
    sb_t e;
    e.x = x;
    e.y = y;
    model(x, y, e.exp_ang, e.exp_mag);
    e.exp_edge  = ce_count + LAT;
    e.ideal_ang = ia;
    e.ideal_mag = im;
    e.chk_ang   = ca;
    sb.push_back(e);
  endtask

  // One cycle of stimulus; an accepted sample enters the scoreboard with its ideal result.
  task automatic drive(input bit ce, input bit vld, input int x, input int y);
    @(negedge clock);
    bus.ce       = ce;
    bus.valid_in = vld;
    bus.x_in     = W'(x);
    bus.y_in     = W'(y);
    if (ce && vld)
      push(x, y, $atan2(real'(y), real'(x)) * 1024.0, $sqrt(real'(x * x + y * y)), !(x == 0 && y == 0));
  endtask

  task automatic drive_ideal(input int x, input int y, input real ia, input real im);
    @(negedge clock);
    bus.ce       = 1'b1;
    bus.valid_in = 1'b1;
    bus.x_in     = W'(x);
    bus.y_in     = W'(y);
    push(x, y, ia, im, 1'b1);
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 64) begin
      drive(1'b1, 1'b0, 0, 0);
      n++;
    end
    n_checks++;
    if (sb.size() != 0) begin
      $display("FAIL %s_drain: %0d results still pending, required 0", name, sb.size());
      n_errors++;
      sb.delete();
    end
  endtask

  // Monitor: one comparison set per ce-enabled edge that presents a valid result.
  initial begin : monitor
    bit  ce_at_edge;
    sb_t e;
    int  got_ang, got_mag;
    real d;
    ce_count  = 0;
    out_count = 0;
    forever begin
      @(posedge clock);
      ce_at_edge = bus.ce;
      if (ce_at_edge && reset) ce_count++;
      @(negedge clock);
      if (ce_at_edge && reset && bus.valid_out === 1'b1) begin
        out_count++;
        got_ang = int'(bus.angle_out);
        got_mag = int'(bus.mag_out);
        n_checks++;
        if (sb.size() == 0) begin
          $display("FAIL unexpected_valid: valid_out=1 at ce edge %0d, required no pending result", ce_count);
          n_errors++;
        end else begin
          e = sb.pop_front();
          if (ce_count !== e.exp_edge) begin
            $display("FAIL latency (%0d,%0d): result at ce edge %0d, required %0d", e.x, e.y, ce_count, e.exp_edge);
            n_errors++;
          end
          n_checks++;
          if (got_mag !== e.exp_mag) begin
            $display("FAIL mag_exact (%0d,%0d): got %0d required %0d", e.x, e.y, got_mag, e.exp_mag);
            n_errors++;
          end
          n_checks++;
          d = real'(got_mag) - e.ideal_mag;
          if (d < 0.0) d = -d;
          if (d > real'(MAG_TOL)) begin
            $display("FAIL mag_ideal (%0d,%0d): got %0d required %f +/- %0d", e.x, e.y, got_mag, e.ideal_mag, MAG_TOL);
            n_errors++;
          end
          if (e.chk_ang) begin
            n_checks++;
            if (got_ang !== e.exp_ang) begin
              $display("FAIL angle_exact (%0d,%0d): got %0d required %0d", e.x, e.y, got_ang, e.exp_ang);
              n_errors++;
            end
            n_checks++;
            d = real'(got_ang) - e.ideal_ang;
            if (d > PI_R * 1024.0)  d = d - 2.0 * PI_R * 1024.0;
            if (d < -PI_R * 1024.0) d = d + 2.0 * PI_R * 1024.0;
            if (d < 0.0) d = -d;
            if (d > real'(ANG_TOL)) begin
              $display("FAIL angle_ideal (%0d,%0d): got %0d required %f +/- %0d", e.x, e.y, got_ang, e.ideal_ang, ANG_TOL);
              n_errors++;
            end
          end
        end
      end
    end
  end

  task automatic test_reset();
    reset        = 1'b0;
    bus.ce       = 1'b1;
    bus.valid_in = 1'b1;
    bus.x_in     = W'(100);
    bus.y_in     = W'(200);
    repeat (3) @(negedge clock);
    n_checks += 3;
    if (bus.valid_out !== 1'b0) begin
      $display("FAIL reset_valid: got %b required 0", bus.valid_out); n_errors++;
    end
    if (bus.angle_out !== '0) begin
      $display("FAIL reset_angle: got %0d required 0", bus.angle_out); n_errors++;
    end
    if (bus.mag_out !== '0) begin
      $display("FAIL reset_mag: got %0d required 0", bus.mag_out); n_errors++;
    end
    bus.valid_in = 1'b0;
    reset        = 1'b1;
    drive(1'b1, 1'b0, 0, 0);
  endtask

  task automatic test_directed();
    int dx [9] = '{1024, 0, 0, -1024, 724, 0, -724, -500, 300};
    int dy [9] = '{0, 1024, -1024, 0, 724, 0, -724, 800, -900};
    for (int i = 0; i < 9; i++) drive(1'b1, 1'b1, dx[i], dy[i]);
    drain("directed");
  endtask

  task automatic test_back_to_back();
    int x, y;
    for (int i = 0; i < 64; i++) begin
      do begin
        x = int'($urandom_range(2048)) - 1024;
        y = int'($urandom_range(2048)) - 1024;
      end while (x * x + y * y < 512 * 512);
      rnd_x[i] = x;
      rnd_y[i] = y;
    end
    for (int i = 0; i < 64; i++) drive(1'b1, 1'b1, rnd_x[i], rnd_y[i]);
    drain("back_to_back");
  endtask

  // Same samples under random ce and sparse valid; stalled cycles offer junk that must be ignored.
  task automatic test_ce_toggle();
    int k, cyc;
    bit ce, vld;
    k   = 0;
    cyc = 0;
    while (k < 64 && cyc < 2000) begin
      ce  = ($urandom_range(2) != 0);
      vld = ($urandom_range(2) == 0);
      if (ce && vld) begin
        drive(1'b1, 1'b1, rnd_x[k], rnd_y[k]);
        k++;
      end else if (!ce) begin
        drive(1'b0, vld, int'($urandom_range(2048)) - 1024, int'($urandom_range(2048)) - 1024);
      end else begin
        drive(1'b1, 1'b0, 0, 0);
      end
      cyc++;
    end
    n_checks++;
    if (k != 64) begin
      $display("FAIL ce_toggle_issue: issued %0d samples, required 64", k);
      n_errors++;
    end
    drain("ce_toggle");
  endtask

  task automatic test_reset_midstream();
    int snap;
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b1, rnd_x[i], rnd_y[i]);
    @(posedge clock);
    #2;
    reset = 1'b0;
    #1;
    n_checks += 3;
    if (bus.valid_out !== 1'b0) begin
      $display("FAIL midreset_valid: got %b required 0", bus.valid_out); n_errors++;
    end
    if (bus.angle_out !== '0) begin
      $display("FAIL midreset_angle: got %0d required 0", bus.angle_out); n_errors++;
    end
    if (bus.mag_out !== '0) begin
      $display("FAIL midreset_mag: got %0d required 0", bus.mag_out); n_errors++;
    end
    sb.delete();
    drive(1'b1, 1'b0, 0, 0);
    drive(1'b1, 1'b0, 0, 0);
    @(negedge clock);
    reset = 1'b1;
    snap  = out_count;
    repeat (20) drive(1'b1, 1'b0, 0, 0);
    n_checks++;
    if (out_count != snap) begin
      $display("FAIL midreset_stale: %0d results after release, required 0", out_count - snap);
      n_errors++;
    end
    drive(1'b1, 1'b1, rnd_x[10], rnd_y[10]);
    drive(1'b1, 1'b1, rnd_x[11], rnd_y[11]);
    drain("midreset");
  endtask

  // Unit vectors at angle a from real cos/sin must come back as (a, 1024).
  task automatic test_loopback();
    int x, y;
    real ar;
    for (int a = -1608; a <= 1608; a += 134) begin
      ar = real'(a) / 1024.0;
      x  = int'(1024.0 * $cos(ar));
      y  = int'(1024.0 * $sin(ar));
      if (x > 1024) x = 1024;
      if (y > 1024) y = 1024;
      if (y < -1024) y = -1024;
      drive_ideal(x, y, real'(a), 1024.0);
    end
    drain("loopback");
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_directed();
    test_back_to_back();
    test_ce_toggle();
    test_reset_midstream();
    test_loopback();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
